disp_queue_mp: RTL and testbench
================================

Name: disp_queue_mp

Overview:
- Parametrised multi-port, in-order dispatch queue between rename and the issue queues.
- Generalises the single integer dispatch-queue entry format to any packed payload, configurable depth, and independent enqueue/dequeue widths.
- Adds all-or-nothing group enqueue, prefix-ordered partial dequeue, squash flush, and occupancy reporting.

Parameters:
- DEPTH, 16, number of entries; power of 2, >= 2*ENQ_WIDTH.
- ENQ_WIDTH, 4, enqueue lanes per cycle.
- DEQ_WIDTH, 4, dequeue lanes per cycle; must be <= DEPTH.
- DATA_W, 64, payload bits per entry (packed dispatch-entry image).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_squash  in  1  flush all entries; takes priority over every other input.
- i_enq_valid  in  ENQ_WIDTH  per-lane valid; must be a contiguous prefix from lane 0.
- i_enq_data  in  ENQ_WIDTH*DATA_W  lane payloads; lane k occupies bits [k*DATA_W +: DATA_W].
- o_enq_ready  out  1  group accept.
- o_deq_valid  out  DEQ_WIDTH  lane i holds the i-th oldest entry.
- o_deq_data  out  DEQ_WIDTH*DATA_W  oldest entries, in order.
- i_deq_ready  in  DEQ_WIDTH  consumer ready per lane.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_empty  out  1  occupancy == 0.

Behaviour:
- State:
  - head and tail pointers, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Payload storage array. Payload storage is not reset.
  - count = tail - head (modulo arithmetic). free = DEPTH - count.
- Reset (rst low, asynchronous):
  - head = tail = 0.
  - o_count = 0, o_empty = 1, o_deq_valid = 0, o_enq_ready = 1.
- Enqueue:
  - o_enq_ready = (free >= ENQ_WIDTH) && !i_squash. It is combinational from registered state only.
  - When ready, every lane with i_enq_valid set is written at tail+k, and tail advances by popcount(i_enq_valid).
  - Partial acceptance never occurs.
  - free is computed from start-of-cycle state; slots released by a same-cycle dequeue are not reusable in that cycle.
  - A non-prefix i_enq_valid pattern is illegal; an assertion fires on it.
- Dequeue:
  - o_deq_valid[i] = (count > i) && !i_squash.
  - o_deq_data lane i = entry at head+i, with modulo-DEPTH indexing.
  - Pops = length of the contiguous prefix of lanes with both o_deq_valid and i_deq_ready set. Readiness beyond the first non-ready lane is ignored.
  - head advances by the pop count.
  - Dequeue latency: an entry is visible on o_deq_valid in the cycle after it is enqueued. There is no bypass from enqueue to dequeue.
- Simultaneous enqueue and dequeue: both pointers update in the same edge; next count = count + enq_n - deq_n.
- Squash:
  - On the next edge head = tail = 0, regardless of enqueue/dequeue activity.
  - In the squash cycle o_enq_ready = 0 and o_deq_valid = 0, so no handshake completes.
  - Squash during reset has no effect.
- Wrap-around:
  - Pointers wrap naturally at 2*DEPTH.
  - Full when the indices are equal and the wrap bits differ; empty when both are equal.
  - count never exceeds DEPTH; an assertion checks this.
- No other state machine: the queue state is fully described by (head, tail).

Decomposition:
- Shared package dispq_pkg:
  - Typedef dqPtr_t (pointer with wrap bit).
  - Function ptr_add(ptr, n).
  - Function prefix_len(vec), returning the number of leading ones from lane 0.
  - Reused by other queues (ROB, FTQ).
- Sub-module prefix_count (combinational): computes pop count and enqueue popcount.
- Storage is a plain register array inside the top module.

Test Plan (DEPTH=16, ENQ_WIDTH=4, DEQ_WIDTH=4, DATA_W=64 unless stated):
- Reset mid-operation: fill 7 entries, pull rst low asynchronously between edges -> o_count=0 and o_empty=1 immediately; after rst releases, o_enq_ready=1.
- Fill to full: enqueue 4 per cycle with payloads 0..15, i_deq_ready=0 -> o_count reaches 16 after 4 cycles; o_enq_ready=0 from then on; a 5th group is not accepted (tail unchanged).
- Threshold: count=13 -> o_enq_ready=0 (free=3 < 4). Pop 1 (deq_ready=4'b0001) -> the next cycle has free=4 and o_enq_ready=1.
- Prefix dequeue: 4 entries A,B,C,D, i_deq_ready=4'b1101 -> only A pops (lane1 not ready); next cycle lane0=B and o_count=3.
- Wrap-around with simultaneous enqueue/dequeue: 40 cycles of enqueue 4 / dequeue 4 with an incrementing payload -> dequeued sequence is strictly 0,1,2,...; pointers wrap at least twice; o_count constant at 4 after the first cycle.
- Squash priority: count=9, same cycle i_squash=1 with i_enq_valid=4'b0011 and i_deq_ready=4'hF -> o_enq_ready=0 and o_deq_valid=0 in that cycle; next cycle o_count=0; a following enqueue of 2 gives o_count=2 with data at slots 0 and 1.

Source files
------------

// File: rtl/dispq_pkg.sv
// Shared helpers for pointer-based in-order queues (dispatch queue, ROB, FTQ).
// Provides a default-sized wrap-bit pointer type, modulo pointer addition for
// any pointer width, and a leading-ones (prefix length) counter.
package dispq_pkg;

    localparam int DQ_DEPTH_DEF = 16;
    localparam int DQ_PTR_W     = $clog2(DQ_DEPTH_DEF) + 1;
    localparam int DQ_VEC_MAX   = 32;

    // Pointer with wrap bit in the MSB, sized for the default depth.
    typedef logic [DQ_PTR_W-1:0] dqPtr_t;

    // Add n to a pointer and wrap at 2**ptr_w (index bits plus wrap bit).
    function automatic logic [31:0] ptr_add(input logic [31:0] ptr,
                                            input logic [31:0] n,
                                            input int          ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (ptr + n) & mask;
    endfunction

    // Number of consecutive ones starting at bit 0, looking at 'lanes' bits.
    function automatic logic [5:0] prefix_len(input logic [DQ_VEC_MAX-1:0] vec,
                                              input int                    lanes);
        logic       done;
        logic [5:0] n;
        done = 1'b0;
        n    = 6'd0;
        for (int i = 0; i < DQ_VEC_MAX; i++) begin
            if (i < lanes && !done && vec[i]) begin
                n = n + 6'd1;
            end else begin
                done = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/disp_queue_mp_chk.sv
// Protocol/invariant checker for disp_queue_mp.
// Ports:
//   clk, rst     clock and active-low reset
//   i_enq_valid  enqueue valids, must be a contiguous prefix from lane 0
//   i_count      queue occupancy, must never exceed DEPTH
module disp_queue_mp_chk #(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 4,
    parameter int PTR_W     = 5
) (
    input logic                 clk,
    input logic                 rst,
    input logic [ENQ_WIDTH-1:0] i_enq_valid,
    input logic [PTR_W-1:0]     i_count
);

    // A prefix of ones plus one has no bits in common with the original.
    a_enq_prefix: assert property (@(posedge clk) disable iff (!rst)
        ((i_enq_valid & (i_enq_valid + ENQ_WIDTH'(1))) == '0));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        (i_count <= PTR_W'(DEPTH)));

endmodule

// File: rtl/prefix_count.sv
// Combinational lane counters for the dispatch queue.
// Ports:
//   i_enq_valid  enqueue lane valids (contiguous prefix)
//   i_deq_fire   per-lane dequeue handshake (valid & ready)
//   o_enq_n      number of enqueue lanes set
//   o_deq_n      leading run of completed dequeue handshakes from lane 0
module prefix_count
    import dispq_pkg::*;
#(
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 4
) (
    input  logic [ENQ_WIDTH-1:0]       i_enq_valid,
    input  logic [DEQ_WIDTH-1:0]       i_deq_fire,
    output logic [$clog2(ENQ_WIDTH):0] o_enq_n,
    output logic [$clog2(DEQ_WIDTH):0] o_deq_n
);

    localparam int EW = $clog2(ENQ_WIDTH) + 1;
    localparam int DW = $clog2(DEQ_WIDTH) + 1;

    logic [5:0] w_deq_len;

    // Enqueue lane popcount.
    always_comb begin
        o_enq_n = '0;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            o_enq_n = o_enq_n + EW'(i_enq_valid[k]);
        end
    end

    // Lanes after the first non-firing lane never pop, even if ready.
    assign w_deq_len = prefix_len(DQ_VEC_MAX'(i_deq_fire), DEQ_WIDTH);
    assign o_deq_n   = DW'(w_deq_len);

endmodule

// File: rtl/disp_queue_mp.sv
// Multi-port in-order dispatch queue between rename and the issue queues.
// All-or-nothing group enqueue, prefix-ordered partial dequeue, squash flush.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_squash      flush everything on the next edge; blocks all handshakes
//   i_enq_valid   per-lane enqueue valid (prefix), i_enq_data lane payloads
//   o_enq_ready   whole group accepted this cycle
//   o_deq_valid   lane i holds the i-th oldest entry, o_deq_data payloads
//   i_deq_ready   consumer ready per lane
//   o_count       occupancy, o_empty occupancy == 0
module disp_queue_mp
    import dispq_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 4,
    parameter int DATA_W    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_squash,
    input  logic [ENQ_WIDTH-1:0]        i_enq_valid,
    input  logic [ENQ_WIDTH*DATA_W-1:0] i_enq_data,
    output logic                        o_enq_ready,
    output logic [DEQ_WIDTH-1:0]        o_deq_valid,
    output logic [DEQ_WIDTH*DATA_W-1:0] o_deq_data,
    input  logic [DEQ_WIDTH-1:0]        i_deq_ready,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0]          r_head;
    logic [PTR_W-1:0]          r_tail;
    logic [DATA_W-1:0]         r_mem [DEPTH];

    logic [PTR_W-1:0]          w_count;
    logic [DEQ_WIDTH-1:0]      w_deq_valid;
    logic [$clog2(ENQ_WIDTH):0] w_enq_n;
    logic [$clog2(DEQ_WIDTH):0] w_deq_n;
    logic [AW-1:0]             w_wr_idx [ENQ_WIDTH];
    logic [AW-1:0]             w_rd_idx [DEQ_WIDTH];

    assign w_count = r_tail - r_head;
    assign o_count = w_count;
    assign o_empty = (w_count == '0);

    // Free space is judged on start-of-cycle occupancy only.
    assign o_enq_ready = (w_count <= PTR_W'(DEPTH - ENQ_WIDTH)) && !i_squash;

    genvar g;
    generate
        for (g = 0; g < DEQ_WIDTH; g++) begin : g_deq
            assign w_rd_idx[g]    = r_head[AW-1:0] + AW'(g);
            assign w_deq_valid[g] = (w_count > PTR_W'(g)) && !i_squash;
            assign o_deq_data[g*DATA_W +: DATA_W] = r_mem[w_rd_idx[g]];
        end
        for (g = 0; g < ENQ_WIDTH; g++) begin : g_enq
            assign w_wr_idx[g] = r_tail[AW-1:0] + AW'(g);
        end
    endgenerate

    assign o_deq_valid = w_deq_valid;

    prefix_count #(
        .ENQ_WIDTH (ENQ_WIDTH),
        .DEQ_WIDTH (DEQ_WIDTH)
    ) u_prefix_count (
        .i_enq_valid (i_enq_valid),
        .i_deq_fire  (w_deq_valid & i_deq_ready),
        .o_enq_n     (w_enq_n),
        .o_deq_n     (w_deq_n)
    );

    // Head/tail pointer update; squash returns both to slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (i_squash) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= PTR_W'(ptr_add(32'(r_head), 32'(w_deq_n), PTR_W));
            if (o_enq_ready) begin
                r_tail <= PTR_W'(ptr_add(32'(r_tail), 32'(w_enq_n), PTR_W));
            end
        end
    end

    // Payload storage write (intentionally not reset).
    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (o_enq_ready && i_enq_valid[k]) begin
                r_mem[w_wr_idx[k]] <= i_enq_data[k*DATA_W +: DATA_W];
            end
        end
    end

    disp_queue_mp_chk #(
        .DEPTH     (DEPTH),
        .ENQ_WIDTH (ENQ_WIDTH),
        .PTR_W     (PTR_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_enq_valid (i_enq_valid),
        .i_count     (w_count)
    );

endmodule

// File: tb/tb_disp_queue_mp.sv
// Self-checking bench for disp_queue_mp against a queue-based reference model.
module tb_disp_queue_mp;

    localparam int DEPTH = 16;
    localparam int EW    = 4;
    localparam int DW    = 4;
    localparam int DATA_W = 64;

    logic                 clk;
    logic                 rst;
    logic                 i_squash;
    logic [EW-1:0]        i_enq_valid;
    logic [EW*DATA_W-1:0] i_enq_data;
    logic                 o_enq_ready;
    logic [DW-1:0]        o_deq_valid;
    logic [DW*DATA_W-1:0] o_deq_data;
    logic [DW-1:0]        i_deq_ready;
    logic [4:0]           o_count;
    logic                 o_empty;

    disp_queue_mp #(
        .DEPTH (DEPTH), .ENQ_WIDTH (EW), .DEQ_WIDTH (DW), .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_squash    (i_squash),
        .i_enq_valid (i_enq_valid),
        .i_enq_data  (i_enq_data),
        .o_enq_ready (o_enq_ready),
        .o_deq_valid (o_deq_valid),
        .o_deq_data  (o_deq_data),
        .i_deq_ready (i_deq_ready),
        .o_count     (o_count),
        .o_empty     (o_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] model_q[$];
    logic [63:0] pay_base = 64'h0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at posedge+1, check at negedge, update model, advance.
    task automatic step(input logic sq, input logic [EW-1:0] ev, input logic [DW-1:0] dr);
        int          sz;
        int          pops;
        int          nenq;
        logic        exp_rdy;
        logic [DW-1:0] exp_dv;
        i_squash    = sq;
        i_enq_valid = ev;
        i_deq_ready = dr;
        for (int k = 0; k < EW; k++) i_enq_data[k*DATA_W +: DATA_W] = pay_base + 64'(k);
        @(negedge clk);
        sz      = model_q.size();
        exp_rdy = !sq && (DEPTH - sz >= EW);
        for (int i = 0; i < DW; i++) exp_dv[i] = !sq && (sz > i);
        chk("enq_ready", 64'(o_enq_ready), 64'(exp_rdy));
        chk("deq_valid", 64'(o_deq_valid), 64'(exp_dv));
        chk("count", 64'(o_count), 64'(sz));
        chk("empty", 64'(o_empty), 64'(sz == 0));
        for (int i = 0; i < DW; i++)
            if (exp_dv[i]) chk($sformatf("deq_data%0d", i), o_deq_data[i*DATA_W +: DATA_W], model_q[i]);
        if (sq) begin
            model_q.delete();
        end else begin
            pops = 0;
            while (pops < DW && exp_dv[pops] && dr[pops]) pops++;
            for (int i = 0; i < pops; i++) void'(model_q.pop_front());
            if (exp_rdy) begin
                nenq = 0;
                for (int k = 0; k < EW; k++) if (ev[k]) begin
                    model_q.push_back(pay_base + 64'(k));
                    nenq++;
                end
                pay_base = pay_base + 64'(nenq);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] pfx(input int n);
        logic [EW-1:0] v;
        v = '0;
        for (int i = 0; i < EW; i++) if (i < n) v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        rst = 1'b0; i_squash = 1'b0; i_enq_valid = '0; i_deq_ready = '0; i_enq_data = '0;
        #12;
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_deq_valid", 64'(o_deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(o_enq_ready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset mid-operation after 7 entries.
        step(1'b0, 4'hF, 4'h0);
        step(1'b0, 4'h7, 4'h0);
        i_enq_valid = '0; i_deq_ready = '0;
        #3 rst = 1'b0;
        #1;
        chk("midrst_count", 64'(o_count), 64'd0);
        chk("midrst_empty", 64'(o_empty), 64'd1);
        model_q.delete();
        #2 rst = 1'b1;
        #1 chk("midrst_enq_ready", 64'(o_enq_ready), 64'd1);
        @(posedge clk); #1;

        // Fill to full with payloads 0..15, then an extra rejected group.
        pay_base = 64'h0;
        for (int c = 0; c < 6; c++) step(1'b0, 4'hF, 4'h0);
        step(1'b0, 4'h0, 4'h0);

        // Threshold at 13 entries.
        step(1'b1, 4'h0, 4'h0);
        for (int c = 0; c < 3; c++) step(1'b0, 4'hF, 4'h0);
        step(1'b0, 4'h1, 4'h0);
        step(1'b0, 4'h0, 4'h1);
        step(1'b0, 4'hF, 4'h0);

        // Prefix dequeue: ready 1101 pops only lane 0.
        step(1'b1, 4'h0, 4'h0);
        step(1'b0, 4'hF, 4'h0);
        step(1'b0, 4'h0, 4'hD);
        step(1'b0, 4'h0, 4'h0);

        // Wrap-around with simultaneous enqueue/dequeue and incrementing payload.
        step(1'b1, 4'h0, 4'h0);
        pay_base = 64'h0;
        for (int c = 0; c < 40; c++) step(1'b0, 4'hF, 4'hF);

        // Squash priority at count 9.
        step(1'b1, 4'h0, 4'h0);
        step(1'b0, 4'hF, 4'h0);
        step(1'b0, 4'hF, 4'h0);
        step(1'b0, 4'h1, 4'h0);
        step(1'b1, 4'h3, 4'hF);
        step(1'b0, 4'h3, 4'h0);
        step(1'b0, 4'h0, 4'h0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(39) == 0), pfx($urandom_range(EW)), DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
